// File: rtl/fsm_bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words shifted out MSB-first, each bit held DIV cycles.
// Latency: first bit 1 cycle after accept; one-deep pending word keeps back-to-back words gapless.
// Backpressure: load_ready = !pend_full; a word arriving on the last-bit edge with pend empty starts directly.
module fsm_bit_serializer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [7:0]    DIV_LAST = 8'(DIV - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_reg, shift_nxt;
    logic [WIDTH-1:0] pend_reg, pend_nxt;
    logic             pend_full, pend_full_nxt;
    logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]       div_cnt, div_cnt_nxt;
    logic             ser_valid_nxt;
    logic             word_done_nxt;
    logic             xfer;
    logic             word_end;

    assign load_ready = !pend_full;
    assign xfer       = load_valid && load_ready;
    assign word_end   = (div_cnt == 8'd0) && (bit_cnt == '0);
    // ser_out is the MSB of the shifter, so it naturally holds the last bit once idle.
    assign ser_out    = shift_reg[WIDTH-1];
    assign busy       = (state == SHIFT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            pend_reg  <= '0;
            pend_full <= 1'b0;
            bit_cnt   <= '0;
            div_cnt   <= 8'd0;
            ser_valid <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            pend_reg  <= pend_nxt;
            pend_full <= pend_full_nxt;
            bit_cnt   <= bit_cnt_nxt;
            div_cnt   <= div_cnt_nxt;
            ser_valid <= ser_valid_nxt;
            word_done <= word_done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        shift_nxt     = shift_reg;
        pend_nxt      = pend_reg;
        pend_full_nxt = pend_full;
        bit_cnt_nxt   = bit_cnt;
        div_cnt_nxt   = div_cnt;
        ser_valid_nxt = 1'b0;
        word_done_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (xfer) begin
                    shift_nxt     = load_data;
                    bit_cnt_nxt   = BIT_LAST;
                    div_cnt_nxt   = DIV_LAST;
                    ser_valid_nxt = 1'b1;
                    state_nxt     = SHIFT;
                end
            end

            SHIFT: begin
                if (!word_end) begin
                    if (xfer) begin
                        pend_nxt      = load_data;
                        pend_full_nxt = 1'b1;
                    end
                    if (div_cnt != 8'd0) begin
                        div_cnt_nxt = div_cnt - 8'd1;
                    end else begin
                        shift_nxt     = {shift_reg[WIDTH-2:0], 1'b0};
                        bit_cnt_nxt   = bit_cnt - BW'(1);
                        div_cnt_nxt   = DIV_LAST;
                        ser_valid_nxt = 1'b1;
                    end
                end else begin
                    word_done_nxt = 1'b1;
                    // Pending word wins; xfer cannot be high then since load_ready is low.
                    if (pend_full) begin
                        shift_nxt     = pend_reg;
                        pend_full_nxt = 1'b0;
                        bit_cnt_nxt   = BIT_LAST;
                        div_cnt_nxt   = DIV_LAST;
                        ser_valid_nxt = 1'b1;
                    end else if (xfer) begin
                        shift_nxt     = load_data;
                        bit_cnt_nxt   = BIT_LAST;
                        div_cnt_nxt   = DIV_LAST;
                        ser_valid_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fsm_bit_serializer.sv
// Directed bench for fsm_bit_serializer with DIV=1, DIV=2 and DIV=4 instances sharing clock and reset.
module tb_fsm_bit_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       v1, v2, v4;
    logic [7:0] d1, d2, d4;
    logic       r1, so1, sv1, b1, wd1;
    logic       r2, so2, sv2, b2, wd2;
    logic       r4, so4, sv4, b4, wd4;

    int n_cmp = 0;
    int n_bad = 0;

    fsm_bit_serializer #(.WIDTH(8), .DIV(1)) u_d1 (
        .clk(clk), .reset(reset), .load_valid(v1), .load_data(d1), .load_ready(r1),
        .ser_out(so1), .ser_valid(sv1), .busy(b1), .word_done(wd1)
    );
    fsm_bit_serializer #(.WIDTH(8), .DIV(2)) u_d2 (
        .clk(clk), .reset(reset), .load_valid(v2), .load_data(d2), .load_ready(r2),
        .ser_out(so2), .ser_valid(sv2), .busy(b2), .word_done(wd2)
    );
    fsm_bit_serializer #(.WIDTH(8), .DIV(4)) u_d4 (
        .clk(clk), .reset(reset), .load_valid(v4), .load_data(d4), .load_ready(r4),
        .ser_out(so4), .ser_valid(sv4), .busy(b4), .word_done(wd4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: words streamed back to back starting at cycle 1, packed as {so,sv,busy,done,rdy}.
    function automatic logic [4:0] exp_vec(logic [31:0] s, int nb, int dv, int c, logic rdy);
        int   idx;
        int   tot;
        logic so, sv, bz, wd;
        idx = (c - 1) / dv;
        tot = nb * dv;
        so  = (idx < nb) ? s[nb-1-idx] : s[0];
        sv  = (c <= tot) && (((c - 1) % dv) == 0);
        bz  = (c <= tot);
        wd  = (c > 8 * dv) && (c <= tot + 1) && (((c - 1) % (8 * dv)) == 0);
        return {so, sv, bz, wd, rdy};
    endfunction

    task automatic test_reset;
        logic [4:0] obs;
        reset = 1'b0;
        v1 = 1'b1; d1 = 8'hFF;
        v2 = 1'b1; d2 = 8'hFF;
        v4 = 1'b1; d4 = 8'hFF;
        repeat (3) tick();
        obs = {so1, sv1, b1, wd1, r1};
        n_cmp++; if (obs !== 5'b00001) begin n_bad++; $display("FAIL reset_d1: got %b want 00001", obs); end
        obs = {so2, sv2, b2, wd2, r2};
        n_cmp++; if (obs !== 5'b00001) begin n_bad++; $display("FAIL reset_d2: got %b want 00001", obs); end
        obs = {so4, sv4, b4, wd4, r4};
        n_cmp++; if (obs !== 5'b00001) begin n_bad++; $display("FAIL reset_d4: got %b want 00001", obs); end
        v1 = 1'b0; v2 = 1'b0; v4 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        obs = {so1, sv1, b1, wd1, r1};
        n_cmp++; if (obs !== 5'b00001) begin n_bad++; $display("FAIL post_reset_d1: got %b want 00001", obs); end
        obs = {so4, sv4, b4, wd4, r4};
        n_cmp++; if (obs !== 5'b00001) begin n_bad++; $display("FAIL post_reset_d4: got %b want 00001", obs); end
    endtask

    task automatic test_single_div1;
        logic [4:0] obs, exp;
        v1 = 1'b1; d1 = 8'hF0;
        tick();
        v1 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            obs = {so1, sv1, b1, wd1, r1};
            exp = exp_vec(32'hF0, 8, 1, c, 1'b1);
            n_cmp++;
            if (obs !== exp) begin n_bad++; $display("FAIL single_div1 cycle %0d: got %b want %b (so,sv,busy,done,rdy)", c, obs, exp); end
            tick();
        end
    endtask

    task automatic test_div4;
        logic [4:0] obs, exp;
        v4 = 1'b1; d4 = 8'h81;
        tick();
        v4 = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            obs = {so4, sv4, b4, wd4, r4};
            exp = exp_vec(32'h81, 8, 4, c, 1'b1);
            n_cmp++;
            if (obs !== exp) begin n_bad++; $display("FAIL div4 cycle %0d: got %b want %b (so,sv,busy,done,rdy)", c, obs, exp); end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] obs, exp;
        for (int c = 0; c <= 18; c++) begin
            v1 = (c <= 1);
            d1 = (c == 0) ? 8'hA5 : 8'h3C;
            if (c >= 1) begin
                obs = {so1, sv1, b1, wd1, r1};
                exp = exp_vec(32'hA53C, 16, 1, c, !(c >= 2 && c <= 8));
                n_cmp++;
                if (obs !== exp) begin n_bad++; $display("FAIL back_to_back cycle %0d: got %b want %b (so,sv,busy,done,rdy)", c, obs, exp); end
            end
            tick();
        end
        v1 = 1'b0;
    endtask

    task automatic test_hold_valid;
        logic [4:0] obs, exp;
        int         acc;
        int         c_cyc;
        logic       c_taken;
        acc = 0; c_cyc = -1; c_taken = 1'b0;
        for (int c = 0; c <= 26; c++) begin
            v1 = (c <= 1) || !c_taken;
            d1 = (c == 0) ? 8'h96 : (c == 1) ? 8'h3C : 8'h0F;
            if (c >= 1) begin
                obs = {so1, sv1, b1, wd1, r1};
                exp = exp_vec(32'h963C0F, 24, 1, c, !((c >= 2 && c <= 8) || (c >= 10 && c <= 16)));
                n_cmp++;
                if (obs !== exp) begin n_bad++; $display("FAIL hold_valid cycle %0d: got %b want %b (so,sv,busy,done,rdy)", c, obs, exp); end
            end
            if (v1 && r1) begin
                acc++;
                if (c >= 2) begin c_taken = 1'b1; c_cyc = c; end
            end
            tick();
            v1 = 1'b0;
        end
        n_cmp++; if (acc !== 3) begin n_bad++; $display("FAIL hold_valid_accepts: got %0d want 3", acc); end
        n_cmp++; if (c_cyc !== 9) begin n_bad++; $display("FAIL hold_valid_accept_cycle: got %0d want 9", c_cyc); end
    endtask

    task automatic test_bypass;
        logic [4:0] obs, exp;
        for (int c = 0; c <= 34; c++) begin
            v2 = (c == 0) || (c == 16);
            d2 = (c == 0) ? 8'h00 : 8'hFF;
            if (c >= 1) begin
                obs = {so2, sv2, b2, wd2, r2};
                exp = exp_vec(32'h00FF, 16, 2, c, 1'b1);
                n_cmp++;
                if (obs !== exp) begin n_bad++; $display("FAIL bypass cycle %0d: got %b want %b (so,sv,busy,done,rdy)", c, obs, exp); end
            end
            tick();
        end
        v2 = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [4:0] obs, exp;
        v1 = 1'b1; d1 = 8'hFF;
        tick();
        v1 = 1'b0;
        tick();
        tick();
        obs = {so1, sv1, b1, wd1, r1};
        n_cmp++; if (obs !== 5'b11101) begin n_bad++; $display("FAIL reset_mid_bit3: got %b want 11101", obs); end
        #2 reset = 1'b0;
        #1;
        obs = {so1, sv1, b1, wd1, r1};
        n_cmp++; if (obs !== 5'b00001) begin n_bad++; $display("FAIL reset_mid_async: got %b want 00001", obs); end
        tick();
        @(negedge clk);
        reset = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            obs = {so1, sv1, b1, wd1, r1};
            n_cmp++; if (obs !== 5'b00001) begin n_bad++; $display("FAIL reset_mid_residual %0d: got %b want 00001", c, obs); end
            tick();
        end
        v1 = 1'b1; d1 = 8'h5A;
        tick();
        v1 = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            obs = {so1, sv1, b1, wd1, r1};
            exp = exp_vec(32'h5A, 8, 1, c, 1'b1);
            n_cmp++;
            if (obs !== exp) begin n_bad++; $display("FAIL reset_mid_restart cycle %0d: got %b want %b (so,sv,busy,done,rdy)", c, obs, exp); end
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        v1 = 1'b0; v2 = 1'b0; v4 = 1'b0;
        d1 = 8'h00; d2 = 8'h00; d4 = 8'h00;
        test_reset();
        test_single_div1();
        test_div4();
        test_back_to_back();
        test_hold_valid();
        test_bypass();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
